// File: rtl/pipelined_mux_arbiter_if.sv
// Handshake bundle for the pipelined N-to-1 word selector: per-channel
// request/accept on the input side, one-entry valid/ready on the output side.
interface pipelined_mux_arbiter_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/pipelined_mux_arbiter.sv
// Registered N-to-1 word selector with fixed-select or round-robin grant and a
// one-entry output buffer that holds its word stable while downstream stalls.
module pipelined_mux_arbiter #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_mux_arbiter_if.slave bus
);

  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] chan_p0;
  logic             vld_p0;
  logic [SEL_W-1:0] ptr_p0;

  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             space;
  logic             xfer;
  int               rr_pos;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
    return (g == SEL_W'(CHANNELS - 1)) ? '0 : g + SEL_W'(1);
  endfunction

  // Round-robin scans from the farthest offset down so the channel nearest
  // the pointer overwrites any later match and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_pos  = 0;
    if (!bus.mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.sel == SEL_W'(k) && bus.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(k);
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        rr_pos = int'(ptr_p0) + i;
        if (rr_pos >= CHANNELS) rr_pos = rr_pos - CHANNELS;
        for (int k = 0; k < CHANNELS; k++) begin
          if (rr_pos == k && bus.in_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(k);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt_idx == SEL_W'(k)) gnt_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign space        = (!vld_p0 || bus.out_ready) && !rst;
  assign xfer         = gnt_vld && space;
  assign bus.in_ready = xfer ? (CHANNELS'(1) << gnt_idx) : '0;

  // Stage p0: output buffer and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      ptr_p0  <= '0;
    end else if (xfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= gnt_data;
      chan_p0 <= gnt_idx;
      ptr_p0  <= next_ptr(gnt_idx);
    end else if (vld_p0 && bus.out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign bus.out_data  = data_p0;
  assign bus.out_chan  = chan_p0;
  assign bus.out_valid = vld_p0;

endmodule

// File: tb/tb_pipelined_mux_arbiter.sv
// Directed bench for pipelined_mux_arbiter: a queue-free behavioural model is
// compared every cycle, plus literal expectations for each scenario.
module tb_pipelined_mux_arbiter;
  localparam int W   = 16;
  localparam int CH  = 16;
  localparam int CH2 = 12;
  localparam int SW  = 4;
  localparam int DW  = CH * W;
  localparam int DW2 = CH2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  pipelined_mux_arbiter_if #(.WIDTH(W), .CHANNELS(CH),  .SEL_W(SW)) bus ();
  pipelined_mux_arbiter_if #(.WIDTH(W), .CHANNELS(CH2), .SEL_W(SW)) bus2 ();

  pipelined_mux_arbiter #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipelined_mux_arbiter #(.WIDTH(W), .CHANNELS(CH2), .SEL_W(SW)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  // Reference model: state after the last edge, rules applied at each negedge
  logic        m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  int          m_chan  = 0;
  int          m_ptr   = 0;
  int          g;
  int          s;
  int          k;
  bit          sp;
  bit          found;
  logic [15:0] er;

  initial forever begin
    @(negedge clk);
    sp = (!m_valid || bus.out_ready) && !rst;
    g  = -1;
    if (bus.mode == 1'b0) begin
      s = int'(bus.sel);
      if (s < CH && ((bus.in_valid >> s) & 16'd1) != 16'd0) g = s;
    end else begin
      found = 1'b0;
      for (int i = 0; i < CH; i++) begin
        k = (m_ptr + i) % CH;
        if (!found && ((bus.in_valid >> k) & 16'd1) != 16'd0) begin
          g     = k;
          found = 1'b1;
        end
      end
    end
    er = (g >= 0 && sp) ? (16'd1 << g) : 16'd0;
    if (chk_en) begin
      chk("model_out_valid", int'(bus.out_valid), int'(m_valid));
      chk("model_out_data",  int'(bus.out_data),  int'(m_data));
      chk("model_out_chan",  int'(bus.out_chan),  m_chan);
      chk("model_in_ready",  int'(bus.in_ready),  int'(er));
    end
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else if (g >= 0 && sp) begin
      m_valid = 1'b1;
      m_data  = 16'(bus.in_data >> (g * W));
      m_chan  = g;
      m_ptr   = (g == CH - 1) ? 0 : g + 1;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]  d;
    logic [DW2-1:0] d2;
    d  = '0;
    d2 = '0;
    for (int i = 0; i < CH; i++)  d  = d  | (DW'(1 << i)  << (i * W));
    for (int i = 0; i < CH2; i++) d2 = d2 | (DW2'(1 << i) << (i * W));
    bus.in_data    = d;   bus.in_valid  = '0; bus.mode  = 1'b0;
    bus.sel        = '0;  bus.out_ready = 1'b1;
    bus2.in_data   = d2;  bus2.in_valid = '0; bus2.mode = 1'b0;
    bus2.sel       = '0;  bus2.out_ready = 1'b1;

    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_data",  int'(bus.out_data),  0);
    chk("reset_chan",  int'(bus.out_chan),  0);

    // Fixed-select sweep
    bus.in_valid = '1;
    for (int i = 0; i < CH; i++) begin
      bus.sel = SW'(i);
      #1;
      chk("sweep_ready", int'(bus.in_ready), 1 << i);
      cyc();
      chk("sweep_data", int'(bus.out_data), 1 << i);
      chk("sweep_chan", int'(bus.out_chan), i);
    end

    // Round-robin rotation from reset
    rst = 1'b1; cyc(); rst = 1'b0;
    bus.mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("rr_chan",  int'(bus.out_chan),  i % CH);
      chk("rr_data",  int'(bus.out_data),  1 << (i % CH));
      chk("rr_valid", int'(bus.out_valid), 1);
    end

    // Sparse round-robin with wrap
    rst = 1'b1; cyc(); rst = 1'b0;
    bus.in_valid = 16'h8005;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("sparse_chan", int'(bus.out_chan), (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 15);
    end

    // Backpressure
    rst = 1'b1; cyc(); rst = 1'b0;
    bus.in_valid = '1;
    cyc();
    chk("bp_first_chan", int'(bus.out_chan), 0);
    bus.out_ready = 1'b0;
    #1;
    chk("bp_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_data",  int'(bus.out_data),  16'h0001);
      chk("bp_hold_chan",  int'(bus.out_chan),  0);
      chk("bp_hold_valid", int'(bus.out_valid), 1);
      chk("bp_hold_ready", int'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(bus.in_ready), 16'h0002);
    cyc();
    chk("bp_release_chan",  int'(bus.out_chan),  1);
    chk("bp_release_valid", int'(bus.out_valid), 1);

    // Empty select drains the output
    bus.mode = 1'b0;
    bus.sel = 4'd3;
    bus.in_valid = 16'hFFF7;
    #1;
    chk("empty_ready", int'(bus.in_ready), 0);
    cyc();
    chk("empty_valid", int'(bus.out_valid), 0);
    chk("empty_chan_held", int'(bus.out_chan), 1);

    // Out-of-range select on the 12-channel instance
    bus2.in_valid = 12'hFFF;
    bus2.sel = 4'd13;
    #1;
    chk("oor_ready", int'(bus2.in_ready), 0);
    cyc();
    chk("oor_valid", int'(bus2.out_valid), 0);
    bus2.sel = 4'd11;
    #1;
    chk("ch12_ready", int'(bus2.in_ready), 12'h800);
    cyc();
    chk("ch12_chan",  int'(bus2.out_chan),  11);
    chk("ch12_data",  int'(bus2.out_data),  16'h0800);
    chk("ch12_valid", int'(bus2.out_valid), 1);

    // Reset mid-stall
    bus.in_valid = '1;
    bus.sel = 4'd10;
    cyc();
    chk("stall_load", int'(bus.out_data), 16'h0400);
    bus.out_ready = 1'b0;
    cyc();
    chk("stall_held", int'(bus.out_data), 16'h0400);
    rst = 1'b1;
    #1;
    chk("rst_ready", int'(bus.in_ready), 0);
    cyc();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data",  int'(bus.out_data),  0);
    chk("rst_chan",  int'(bus.out_chan),  0);
    rst = 1'b0;
    bus.mode = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", int'(bus.in_ready), 16'h0001);
    cyc();
    chk("post_rst_chan", int'(bus.out_chan), 0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
